// File: rtl/me_pad_stream_if_pkg.sv
// Shared sizing helpers and types for the ME pad-limited host interface.
// Beats are packed LSB-first on both the input and the result side.
package me_pkg;
    localparam int DEF_PAD_W = 16;
    localparam int DEF_CUR_W = 32;
    localparam int DEF_REF_W = 64;
    localparam int DEF_SAD_W = 14;
    localparam int DEF_MV_W  = 5;
    localparam int DEF_OUT_W = 8;

    function automatic int res_w(input int sad_w, input int mv_w);
        return sad_w + 2 * mv_w;
    endfunction

    function automatic int res_beats(input int rw, input int out_w);
        return (rw + out_w - 1) / out_w;
    endfunction

    // Counter width that stays at least 1 bit for single-beat words.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {RES_IDLE, RES_SEND} res_state_t;
endpackage

// File: rtl/me_pad_stream_if_if.sv
// Pad-side and core-side signal bundle; the design sits on the slave modport.
interface me_pad_stream_if_if
    import me_pkg::*;
#(
    parameter int PAD_W = DEF_PAD_W,
    parameter int CUR_W = DEF_CUR_W,
    parameter int REF_W = DEF_REF_W,
    parameter int SAD_W = DEF_SAD_W,
    parameter int MV_W  = DEF_MV_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic [PAD_W-1:0] pad_data_i;
    logic             pad_sel_i;
    logic             pad_valid_i;
    logic             pad_ready_o;
    logic [CUR_W-1:0] core_cur_o;
    logic [REF_W-1:0] core_ref_o;
    logic             core_cur_avail_o;
    logic             core_ref_avail_o;
    logic             core_cur_read_en_i;
    logic             core_ref_read_en_i;
    logic [SAD_W-1:0] core_msad_i;
    logic [MV_W-1:0]  core_col_i;
    logic [MV_W-1:0]  core_row_i;
    logic             core_data_valid_i;
    logic [OUT_W-1:0] res_data_o;
    logic             res_valid_o;
    logic             res_last_o;
    logic             res_ready_i;
    logic             underrun_o;
    logic             overflow_o;

    modport slave (
        input  pad_data_i, pad_sel_i, pad_valid_i,
        output pad_ready_o,
        output core_cur_o, core_ref_o, core_cur_avail_o, core_ref_avail_o,
        input  core_cur_read_en_i, core_ref_read_en_i,
        input  core_msad_i, core_col_i, core_row_i, core_data_valid_i,
        output res_data_o, res_valid_o, res_last_o,
        input  res_ready_i,
        output underrun_o, overflow_o
    );

    modport master (
        output pad_data_i, pad_sel_i, pad_valid_i,
        input  pad_ready_o,
        input  core_cur_o, core_ref_o, core_cur_avail_o, core_ref_avail_o,
        output core_cur_read_en_i, core_ref_read_en_i,
        output core_msad_i, core_col_i, core_row_i, core_data_valid_i,
        input  res_data_o, res_valid_o, res_last_o,
        output res_ready_i,
        input  underrun_o, overflow_o
    );
endinterface

// File: rtl/me_pad_stream_if_asm.sv
// One input channel: gathers PAD_W beats into a WORD_W word and holds it in a
// single-entry buffer until the core reads it.
module me_word_assembler
    import me_pkg::*;
#(
    parameter int PAD_W  = 16,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_beat_vld,
    input  logic [PAD_W-1:0]  i_beat_data,
    output logic              o_ready,
    input  logic              i_rd_en,
    output logic [WORD_W-1:0] o_word,
    output logic              o_avail,
    output logic              o_underrun
);
    localparam int BEATS = WORD_W / PAD_W;
    localparam int CW    = cnt_w(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if (WORD_W % PAD_W != 0) begin : g_bad_width
        $error("me_word_assembler: WORD_W must be a multiple of PAD_W");
    end

    logic [CW-1:0]     r_cnt;
    logic [WORD_W-1:0] r_asm;
    logic [WORD_W-1:0] r_word;
    logic              r_avail;
    logic              r_underrun;
    logic [WORD_W-1:0] w_asm_nxt;
    logic              w_last;
    logic              w_acc;
    logic              w_done;

    // Only the final beat can stall: it needs a free buffer slot, and a slot
    // being read this cycle counts as free.
    assign w_last  = (r_cnt == LAST);
    assign o_ready = !r_avail || i_rd_en || !w_last;
    assign w_acc   = i_beat_vld && o_ready;
    assign w_done  = w_acc && w_last;

    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[r_cnt*PAD_W +: PAD_W] = i_beat_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_asm      <= '0;
            r_word     <= '0;
            r_avail    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_acc) begin
                r_asm <= w_asm_nxt;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_done) begin
                r_word  <= w_asm_nxt;
                r_avail <= 1'b1;
            end else if (i_rd_en && r_avail) begin
                r_avail <= 1'b0;
            end
            if (i_rd_en && !r_avail)
                r_underrun <= 1'b1;
        end
    end

    assign o_word     = r_word;
    assign o_avail    = r_avail;
    assign o_underrun = r_underrun;
endmodule

// File: rtl/me_pad_stream_if.sv
// Chip-top glue between the narrow pad bus and inst_ME: two word assemblers on
// the input side, a one-entry hold register plus beat serialiser on the result side.
module me_pad_stream_if
    import me_pkg::*;
#(
    parameter int PAD_W = DEF_PAD_W,
    parameter int CUR_W = DEF_CUR_W,
    parameter int REF_W = DEF_REF_W,
    parameter int SAD_W = DEF_SAD_W,
    parameter int MV_W  = DEF_MV_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic clk,
    input  logic rst,
    me_pad_stream_if_if.slave bus
);
    localparam int RES_W     = res_w(SAD_W, MV_W);
    localparam int RES_BEATS = res_beats(RES_W, OUT_W);
    localparam int SH_W      = RES_BEATS * OUT_W;
    localparam int IW        = cnt_w(RES_BEATS);

    logic w_cur_ready, w_ref_ready, w_cur_under, w_ref_under;

    me_word_assembler #(.PAD_W(PAD_W), .WORD_W(CUR_W)) u_cur (
        .clk        (clk),
        .rst_n      (rst),
        .i_beat_vld (bus.pad_valid_i && !bus.pad_sel_i),
        .i_beat_data(bus.pad_data_i),
        .o_ready    (w_cur_ready),
        .i_rd_en    (bus.core_cur_read_en_i),
        .o_word     (bus.core_cur_o),
        .o_avail    (bus.core_cur_avail_o),
        .o_underrun (w_cur_under)
    );

    me_word_assembler #(.PAD_W(PAD_W), .WORD_W(REF_W)) u_ref (
        .clk        (clk),
        .rst_n      (rst),
        .i_beat_vld (bus.pad_valid_i && bus.pad_sel_i),
        .i_beat_data(bus.pad_data_i),
        .o_ready    (w_ref_ready),
        .i_rd_en    (bus.core_ref_read_en_i),
        .o_word     (bus.core_ref_o),
        .o_avail    (bus.core_ref_avail_o),
        .o_underrun (w_ref_under)
    );

    assign bus.pad_ready_o = bus.pad_sel_i ? w_ref_ready : w_cur_ready;
    assign bus.underrun_o  = w_cur_under || w_ref_under;

    res_state_t      r_state;
    logic [SH_W-1:0] r_hold;
    logic            r_hold_full;
    logic [SH_W-1:0] r_shift;
    logic [IW-1:0]   r_idx;
    logic            r_valid;
    logic            r_last;
    logic            r_overflow;
    logic [SH_W-1:0] w_res;
    logic            w_take;

    always_comb begin
        w_res = '0;
        w_res[RES_W-1:0] = {bus.core_row_i, bus.core_col_i, bus.core_msad_i};
    end

    // The hold slot frees up whenever the serialiser loads from it this cycle,
    // so a new result landing on that same cycle is not lost.
    assign w_take = r_hold_full &&
                    ((r_state == RES_IDLE) || (bus.res_ready_i && r_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (bus.core_data_valid_i) begin
                if (!r_hold_full || w_take) begin
                    r_hold      <= w_res;
                    r_hold_full <= 1'b1;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (w_take) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RES_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                RES_IDLE: begin
                    if (r_hold_full) begin
                        r_shift <= r_hold;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (RES_BEATS == 1);
                        r_state <= RES_SEND;
                    end
                end
                RES_SEND: begin
                    if (bus.res_ready_i) begin
                        if (r_last) begin
                            if (r_hold_full) begin
                                r_shift <= r_hold;
                                r_idx   <= '0;
                                r_last  <= (RES_BEATS == 1);
                            end else begin
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_state <= RES_IDLE;
                            end
                        end else begin
                            r_shift <= r_shift >> OUT_W;
                            r_idx   <= r_idx + 1'b1;
                            r_last  <= (r_idx == IW'(RES_BEATS - 2));
                        end
                    end
                end
                default: r_state <= RES_IDLE;
            endcase
        end
    end

    assign bus.res_data_o  = r_shift[OUT_W-1:0];
    assign bus.res_valid_o = r_valid;
    assign bus.res_last_o  = r_last;
    assign bus.overflow_o  = r_overflow;
endmodule

// File: tb/tb_me_pad_stream_if.sv
// Self-checking bench: directed input-side sequences plus a table of results
// whose expected beats are queued on issue and compared as the host accepts them.
module tb_me_pad_stream_if;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    me_pad_stream_if_if bus ();

    me_pad_stream_if dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [13:0] msad;
        logic [4:0]  col;
        logic [4:0]  row;
        logic [23:0] exp;
        bit          stall;
    } res_vec_t;

    typedef struct {
        logic [15:0] b0;
        logic [15:0] b1;
        logic [31:0] exp;
    } cur_vec_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } beat_t;

    int checks = 0;
    int errors = 0;
    beat_t q[$];
    res_vec_t vecs[6];
    cur_vec_t cvecs[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic sel, input logic [15:0] d);
        int n = 0;
        logic acc = 1'b0;
        bus.pad_valid_i = 1'b1;
        bus.pad_sel_i   = sel;
        bus.pad_data_i  = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.pad_ready_o;
            cyc();
            n++;
        end
        bus.pad_valid_i = 1'b0;
        if (!acc) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic drive_res(input res_vec_t v, input bit push);
        bus.core_msad_i = v.msad;
        bus.core_col_i  = v.col;
        bus.core_row_i  = v.row;
        bus.core_data_valid_i = 1'b1;
        if (push)
            for (int b = 0; b < 3; b++) q.push_back('{v.exp[b*8 +: 8], (b == 2)});
    endtask

    task automatic drain(input bit stall);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            bus.res_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            n++;
        end
        bus.res_ready_i = 1'b1;
        chk("drain_done", 64'(q.size()), 0);
    endtask

    // Result monitor: compares every accepted beat and checks hold stability.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                chk("res_stable_data", 64'(bus.res_data_o), 64'(prev_data));
                chk("res_stable_last", 64'(bus.res_last_o), 64'(prev_last));
            end
            if (bus.res_valid_o && bus.res_ready_i) begin
                if (q.size() == 0) begin
                    chk("res_unexpected_beat", 64'(bus.res_data_o), 64'hx);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("res_data", 64'(bus.res_data_o), 64'(e.d));
                    chk("res_last", 64'(bus.res_last_o), 64'(e.last));
                end
            end
        end
        prev_stall = rst && bus.res_valid_o && !bus.res_ready_i;
        prev_data  = bus.res_data_o;
        prev_last  = bus.res_last_o;
    end

    initial begin
        vecs[0] = '{14'h1ABC, 5'd3,  5'd17, 24'h88DABC, 1'b0};
        vecs[1] = '{14'h0000, 5'd0,  5'd0,  24'h000000, 1'b0};
        vecs[2] = '{14'h3FFF, 5'd31, 5'd31, 24'hFFFFFF, 1'b1};
        vecs[3] = '{14'h0001, 5'd1,  5'd0,  24'h004001, 1'b1};
        vecs[4] = '{14'h2000, 5'd0,  5'd1,  24'h082000, 1'b0};
        vecs[5] = '{14'h0155, 5'd10, 5'd21, 24'hAA8155, 1'b1};
        cvecs[0] = '{16'hBEEF, 16'hCAFE, 32'hCAFEBEEF};
        cvecs[1] = '{16'h0001, 16'h8000, 32'h80000001};
        cvecs[2] = '{16'hFFFF, 16'h0000, 32'h0000FFFF};

        bus.pad_data_i = '0;
        bus.pad_sel_i = 1'b0;
        bus.pad_valid_i = 1'b0;
        bus.core_cur_read_en_i = 1'b0;
        bus.core_ref_read_en_i = 1'b0;
        bus.core_msad_i = '0;
        bus.core_col_i = '0;
        bus.core_row_i = '0;
        bus.core_data_valid_i = 1'b0;
        bus.res_ready_i = 1'b1;

        cyc(); cyc();
        chk("rst_cur_avail", 64'(bus.core_cur_avail_o), 0);
        chk("rst_ref_avail", 64'(bus.core_ref_avail_o), 0);
        chk("rst_cur", 64'(bus.core_cur_o), 0);
        chk("rst_ref", bus.core_ref_o, 0);
        chk("rst_res_valid", 64'(bus.res_valid_o), 0);
        chk("rst_flags", {62'd0, bus.underrun_o, bus.overflow_o}, 0);
        rst = 1'b1;
        cyc();

        // Plain cur word, then consume it.
        send_beat(1'b0, 16'h1111);
        chk("t1_avail_early", 64'(bus.core_cur_avail_o), 0);
        send_beat(1'b0, 16'h2222);
        chk("t1_avail", 64'(bus.core_cur_avail_o), 1);
        chk("t1_word", 64'(bus.core_cur_o), 64'h22221111);
        bus.core_cur_read_en_i = 1'b1;
        cyc();
        bus.core_cur_read_en_i = 1'b0;
        chk("t1_avail_after_read", 64'(bus.core_cur_avail_o), 0);
        chk("t1_no_underrun", 64'(bus.underrun_o), 0);

        // Interleaved ref and cur beats.
        send_beat(1'b1, 16'h00A0);
        send_beat(1'b0, 16'h3333);
        send_beat(1'b1, 16'h00A1);
        send_beat(1'b1, 16'h00A2);
        send_beat(1'b0, 16'h4444);
        chk("t2_ref_not_yet", 64'(bus.core_ref_avail_o), 0);
        send_beat(1'b1, 16'h00A3);
        chk("t2_ref_avail", 64'(bus.core_ref_avail_o), 1);
        chk("t2_ref_word", bus.core_ref_o, 64'h00A300A200A100A0);
        chk("t2_cur_word", 64'(bus.core_cur_o), 64'h44443333);
        chk("t2_cur_avail", 64'(bus.core_cur_avail_o), 1);

        // Full cur buffer stalls only the last beat; a read frees it same cycle.
        send_beat(1'b0, 16'h5555);
        bus.pad_valid_i = 1'b1;
        bus.pad_sel_i = 1'b0;
        bus.pad_data_i = 16'h6666;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", 64'(bus.pad_ready_o), 0);
            cyc();
        end
        chk("t3_held_word", 64'(bus.core_cur_o), 64'h44443333);
        bus.core_cur_read_en_i = 1'b1;
        @(negedge clk);
        chk("t3_ready_on_read", 64'(bus.pad_ready_o), 1);
        cyc();
        bus.pad_valid_i = 1'b0;
        bus.core_cur_read_en_i = 1'b0;
        chk("t3_avail_no_bubble", 64'(bus.core_cur_avail_o), 1);
        chk("t3_new_word", 64'(bus.core_cur_o), 64'h66665555);
        bus.core_cur_read_en_i = 1'b1;
        cyc();
        bus.core_cur_read_en_i = 1'b0;
        chk("t3_avail_cleared", 64'(bus.core_cur_avail_o), 0);
        chk("t3_no_underrun", 64'(bus.underrun_o), 0);

        // Underrun: read on an empty cur buffer.
        bus.core_cur_read_en_i = 1'b1;
        cyc();
        bus.core_cur_read_en_i = 1'b0;
        chk("t4_underrun", 64'(bus.underrun_o), 1);
        chk("t4_word_held", 64'(bus.core_cur_o), 64'h66665555);
        chk("t4_avail", 64'(bus.core_cur_avail_o), 0);
        cyc();
        chk("t4_underrun_sticky", 64'(bus.underrun_o), 1);
        bus.core_ref_read_en_i = 1'b1;
        cyc();
        bus.core_ref_read_en_i = 1'b0;
        chk("t4_ref_read", 64'(bus.core_ref_avail_o), 0);

        // Result path: latency on the first vector, then the table.
        chk("t5_idle", 64'(bus.res_valid_o), 0);
        drive_res(vecs[0], 1'b1);
        cyc();
        bus.core_data_valid_i = 1'b0;
        chk("t5_lat1", 64'(bus.res_valid_o), 0);
        cyc();
        chk("t5_lat2", 64'(bus.res_valid_o), 1);
        drain(1'b0);
        for (int i = 1; i < 6; i++) begin
            drive_res(vecs[i], 1'b1);
            cyc();
            bus.core_data_valid_i = 1'b0;
            drain(vecs[i].stall);
        end

        // Back-to-back results keep the serialiser busy.
        drive_res(vecs[2], 1'b1);
        cyc();
        drive_res(vecs[5], 1'b1);
        cyc();
        bus.core_data_valid_i = 1'b0;
        drain(1'b0);
        chk("b2b_no_overflow", 64'(bus.overflow_o), 0);

        // Three pulses against a blocked host: the third is dropped.
        bus.res_ready_i = 1'b0;
        drive_res(vecs[0], 1'b1);
        cyc();
        drive_res(vecs[4], 1'b1);
        cyc();
        drive_res(vecs[3], 1'b0);
        cyc();
        bus.core_data_valid_i = 1'b0;
        chk("t6_overflow", 64'(bus.overflow_o), 1);
        drain(1'b0);
        cyc(); cyc();
        chk("t6_idle_after", 64'(bus.res_valid_o), 0);
        chk("t6_overflow_sticky", 64'(bus.overflow_o), 1);

        // Reset mid-word and mid-result discards partial state.
        send_beat(1'b0, 16'hDEAD);
        drive_res(vecs[2], 1'b0);
        cyc();
        bus.core_data_valid_i = 1'b0;
        rst = 1'b0;
        cyc(); cyc();
        chk("mid_rst_flags", {62'd0, bus.underrun_o, bus.overflow_o}, 0);
        chk("mid_rst_valid", 64'(bus.res_valid_o), 0);
        rst = 1'b1;
        cyc(); cyc();
        chk("post_rst_valid", 64'(bus.res_valid_o), 0);
        for (int i = 0; i < 3; i++) begin
            send_beat(1'b0, cvecs[i].b0);
            send_beat(1'b0, cvecs[i].b1);
            chk("post_rst_word", 64'(bus.core_cur_o), 64'(cvecs[i].exp));
            chk("post_rst_avail", 64'(bus.core_cur_avail_o), 1);
            bus.core_cur_read_en_i = 1'b1;
            cyc();
            bus.core_cur_read_en_i = 1'b0;
        end
        chk("post_rst_underrun", 64'(bus.underrun_o), 0);
        chk("final_queue_empty", 64'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end
endmodule
